// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared processor-wide constants. The address width and boot address are
// defined once here so the program counter, instruction memory and next-PC
// logic all agree on them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package cpu_pkg;

    // Width of every instruction address in the datapath.
    parameter int ADDR_WIDTH = 32;

    // Address the processor starts fetching from after reset.
    parameter logic [ADDR_WIDTH-1:0] PC_RESET_VALUE = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Holds the current instruction address. Every rising clock edge it captures
// the next-PC value computed upstream (PC+4, branch or jump target), or the
// boot address while reset is high. It does no arithmetic, alignment checks
// or masking of its own.
//
// Parameters
//   WIDTH       : address width in bits
//   RESET_VALUE : boot address loaded on reset
//
// Ports
//   Clk      in   1      system clock, rising-edge active
//   Reset    in   1      synchronous, active-high reset
//   Address  in   WIDTH  next PC value from the next-PC logic
//   PCResult out  WIDTH  current PC, driven straight from the register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module program_counter
    import cpu_pkg::*;
#(
    parameter int                WIDTH       = ADDR_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = PC_RESET_VALUE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] PCResult
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // Reset wins over the incoming address. Otherwise the address is loaded
    // every cycle, because the core has no stall or enable path into the PC.
    always_comb begin
        pc_d = Address;
        if (Reset) begin
            pc_d = RESET_VALUE;
        end
    end

    always_ff @(posedge Clk) begin
        pc_q <= pc_d;
    end

    // The output comes only from the register, so nothing on Address or
    // Reset can reach PCResult between edges.
    assign PCResult = pc_q;

`ifndef SYNTHESIS
    // Simulation-only checking: once a reset edge has been seen, the PC must
    // never go unknown.
    logic rst_seen_d;
    logic rst_seen_q;

    always_comb begin
        rst_seen_d = rst_seen_q;
        if (Reset) begin
            rst_seen_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        rst_seen_q <= rst_seen_d;
        if (rst_seen_q === 1'b1) begin
            assert (!$isunknown(PCResult))
                else $error("program_counter: PCResult is unknown after reset");
        end
    end
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
// Directed bench for program_counter: a table of {Reset, Address, expected
// PCResult} records applied one per clock edge, followed by hand-written
// sequences for mid-cycle input changes, reset in mid-run and a reset pulse
// that falls entirely between edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_program_counter;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] PCResult;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    program_counter #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Address  (Address),
        .PCResult (PCResult)
    );

    // 200 ns period: rising edges at 100, 300, 500 ...
    initial begin
        Clk = 1'b0;
        forever #100 Clk = ~Clk;
    end

    // Watchdog: the whole run is a few dozen cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded the limit of %0d ns", $time, 100000);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: PCResult=%h required=%h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic rst, input logic [31:0] addr);
        @(negedge Clk);
        Reset   = rst;
        Address = addr;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        Address = 32'h0000_0040;

        // Reset for two edges (Address ignored), sequential loads, then
        // boundary and unaligned values that must pass through untouched.
        vecs[0] = '{rst: 1'b1, addr: 32'h0000_0040, exp: 32'h0000_0000};
        vecs[1] = '{rst: 1'b1, addr: 32'h0000_0040, exp: 32'h0000_0000};
        vecs[2] = '{rst: 1'b0, addr: 32'h0000_0004, exp: 32'h0000_0004};
        vecs[3] = '{rst: 1'b0, addr: 32'h0000_0008, exp: 32'h0000_0008};
        vecs[4] = '{rst: 1'b0, addr: 32'h0000_000C, exp: 32'h0000_000C};
        vecs[5] = '{rst: 1'b0, addr: 32'hFFFF_FFFC, exp: 32'hFFFF_FFFC};
        vecs[6] = '{rst: 1'b0, addr: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        vecs[7] = '{rst: 1'b0, addr: 32'h0000_0003, exp: 32'h0000_0003};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].addr);
            check($sformatf("vec%0d", i), PCResult, vecs[i].exp);
        end

        // Mid-cycle stability: load 0x10, change Address 50 ns after the
        // edge, PC must hold 0x10 until the next edge and then take 0x20.
        step(1'b0, 32'h0000_0010);
        check("mid_load", PCResult, 32'h0000_0010);
        #49;
        Address = 32'h0000_0020;
        #10;
        check("mid_hold_early", PCResult, 32'h0000_0010);
        @(negedge Clk);
        #90;
        check("mid_hold_late", PCResult, 32'h0000_0010);
        @(posedge Clk);
        #1;
        check("mid_next_edge", PCResult, 32'h0000_0020);

        // Reset in mid-run discards the current PC and ignores Address;
        // the held Address loads on the first edge after deassertion.
        step(1'b0, 32'h0000_1000);
        check("run_pre_reset", PCResult, 32'h0000_1000);
        step(1'b1, 32'h0000_2000);
        check("run_reset", PCResult, 32'h0000_0000);
        step(1'b0, 32'h0000_2000);
        check("run_after_reset", PCResult, 32'h0000_2000);

        // A 50 ns reset pulse strictly between edges must have no effect.
        step(1'b0, 32'h0000_3000);
        check("pulse_pre", PCResult, 32'h0000_3000);
        #49;
        Reset = 1'b1;
        #25;
        check("pulse_during", PCResult, 32'h0000_3000);
        #25;
        Reset   = 1'b0;
        Address = 32'h0000_3004;
        #10;
        check("pulse_after", PCResult, 32'h0000_3000);
        @(posedge Clk);
        #1;
        check("pulse_next_load", PCResult, 32'h0000_3004);
        step(1'b0, 32'h0000_3008);
        check("pulse_next_load2", PCResult, 32'h0000_3008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_program_counter
